line_sram_bridge: RTL and testbench
===================================

LINE_SRAM_BRIDGE -- requirements
Module: line_sram_bridge

Interface
REQ-001 SHALL have parameter WORDS, default 16, meaning 32-bit words per cache line; only 16 is supported.
REQ-002 SHALL have port clkCPU, input, 1, the sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ws_cyc, input, 1, line-side cycle-valid signal.
REQ-005 SHALL have port ws_stb, input, 1, line-side request strobe.
REQ-006 SHALL have port ws_we, input, 1, line-side write (1) or read (0).
REQ-007 SHALL have port ws_addr, input, 32, line byte address; bits [5:0] ignored.
REQ-008 SHALL have port ws_din, input, 512, write line; word i = bits [32i+31:32i].
REQ-009 SHALL have port ws_dm, input, 64, byte enables; word i uses bits [4i+3:4i].
REQ-010 SHALL have port ws_dout, output, 512, read line.
REQ-011 SHALL have port ws_ack, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port sram_stb, output, 1, word request to the SRAM responder.
REQ-013 SHALL have port sram_addr, output, 32, word byte address.
REQ-014 SHALL have port sram_we, output, 4, byte write enables; 0000 = read.
REQ-015 SHALL have port sram_din, output, 32, word write data.
REQ-016 SHALL have port sram_dout, input, 32, word read data.
REQ-017 SHALL have port sram_nak, input, 1, responder not ready; a word completes in the cycle where sram_stb=1 and sram_nak=0.
REQ-018 SHALL have port dbg_state, output, 2, current FSM state encoding.

Function
REQ-019 SHALL implement states IDLE(00), RUN(01), ACK(10), DRAIN(11).
REQ-020 In IDLE, when ws_cyc and ws_stb are 1, the block SHALL latch {ws_addr[31:6],6'b0}, ws_we, ws_din, and ws_dm, clear word index idx to 0, and enter RUN.
REQ-021 In RUN, the block SHALL drive sram_addr=base+4*idx, sram_din=word idx, and sram_we=(latched we ? dm nibble idx : 0000).
REQ-022 In RUN, sram_stb SHALL be 1, except for a write word whose dm nibble is 0000: that word is skipped with sram_stb=0 and idx advances in one cycle.
REQ-023 Once asserted, sram_stb and sram_addr/we/din SHALL be held stable until sram_nak=0.
REQ-024 On completion of a read word, sram_dout SHALL be captured into line word idx.
REQ-025 On completion or skip of word 15, the block SHALL go to ACK; otherwise idx SHALL increment by 1, with no wrap inside a request.
REQ-026 In ACK, ws_ack SHALL be 1 for exactly one cycle and ws_dout SHALL present the captured line (reads); the next state SHALL be IDLE.
REQ-027 ws_dout SHALL hold its value until the next read reaches ACK, and SHALL be unchanged by writes.
REQ-028 Latency: with sram_nak=0, ws_ack SHALL assert 17 cycles after the request-sampling edge; each nak cycle adds one cycle.
REQ-029 If ws_cyc falls in RUN, the block SHALL enter DRAIN, finish any asserted word (hold until nak=0, or exit immediately if none is asserted), then return to IDLE without ws_ack.
REQ-030 A request SHALL be sampled only in IDLE; ws_stb in ACK/DRAIN SHALL be ignored, so back-to-back requests incur one IDLE cycle.
REQ-031 Address arithmetic SHALL be 32-bit; base+4*idx never carries beyond bit 5.

Reset
REQ-032 On rstn=0, the block SHALL immediately reset asynchronously to state IDLE, idx=0, ws_ack=0, ws_dout=0, sram_stb=0, sram_addr=0, sram_we=0, sram_din=0, and dbg_state=00.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no ack, and sram_stb SHALL drop in the same instant.
REQ-034 Release of rstn SHALL be followed by normal IDLE operation on the next edge.

Structure
REQ-035 Shared package line_bridge_pkg SHALL hold the state encoding, WORDS=16, and LINE_BITS=512.
REQ-036 The block SHALL have no sub-module; it is one FSM plus datapath registers.

Verification
REQ-037 Read at 0x1000_0040, zero-wait SRAM returning 0xA000_0000+idx: sram_addr SHALL step 0x1000_0040..0x1000_007C, ws_ack SHALL assert at cycle 17, and ws_dout word i SHALL equal 0xA000_0000+i.
REQ-038 Write with ws_dm=all ones and ws_din word i=i: 16 strobes with sram_we=1111 and sram_din=i SHALL occur, followed by ack.
REQ-039 Write with only dm[7:4]=1111: exactly one strobe SHALL occur, at base+4, and ack SHALL assert at cycle 17.
REQ-040 Read with sram_nak=1 for 3 cycles on word 5: outputs SHALL be held stable and ack SHALL assert at cycle 20.
REQ-041 ws_cyc dropped at word 8 with nak=1 for 2 more cycles: strobe SHALL be held until nak=0, then IDLE with no ack.
REQ-042 rstn pulsed low at word 10: all outputs SHALL go to 0 immediately, and a new read afterwards SHALL complete normally.

Source files
------------

// File: rtl/line_bridge_pkg.sv
// Shared constants and FSM encoding for the cache-line to SRAM word bridge.
package line_bridge_pkg;

    localparam int WORDS     = 16;
    localparam int LINE_BITS = 512;
    localparam int MASK_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ACK   = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Line base is 64-byte aligned, so the word offset never carries past bit 5.
    function automatic logic [31:0] word_addr(input logic [25:0] base, input logic [3:0] idx);
        return {base, idx, 2'b00};
    endfunction

endpackage

// File: rtl/line_sram_bridge.sv
// Splits a 512-bit line request into sixteen 32-bit SRAM word accesses.
// state | meaning
// IDLE  | waiting for ws_cyc & ws_stb; request latched on that edge
// RUN   | walking words 0..15, skipping write words with no byte enables
// ACK   | one-cycle ws_ack, read line presented on ws_dout
// DRAIN | ws_cyc dropped: finish the outstanding word, then IDLE without ack
module line_sram_bridge #(
    parameter int WORDS = 16
) (
    input  logic                                 clkCPU,
    input  logic                                 rstn,
    input  logic                                 ws_cyc,
    input  logic                                 ws_stb,
    input  logic                                 ws_we,
    input  logic [31:0]                          ws_addr,
    input  logic [line_bridge_pkg::LINE_BITS-1:0] ws_din,
    input  logic [line_bridge_pkg::MASK_BITS-1:0] ws_dm,
    output logic [line_bridge_pkg::LINE_BITS-1:0] ws_dout,
    output logic                                 ws_ack,
    output logic                                 sram_stb,
    output logic [31:0]                          sram_addr,
    output logic [3:0]                           sram_we,
    output logic [31:0]                          sram_din,
    input  logic [31:0]                          sram_dout,
    input  logic                                 sram_nak,
    output logic [1:0]                           dbg_state
);

    import line_bridge_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [25:0]            base_q, base_d;
    logic                   we_q, we_d;
    logic [LINE_BITS-1:0]   din_q, din_d;
    logic [MASK_BITS-1:0]   dm_q, dm_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [LINE_BITS-1:0]   dout_q, dout_d;
    logic                   pend_q, pend_d;

    logic [3:0]             nib;
    logic [31:0]            word;
    logic                   active;
    logic                   skip;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^ws_addr[5:0];

    always_comb begin
        nib    = dm_q[{idx_q, 2'b00} +: 4];
        word   = din_q[{idx_q, 5'b00000} +: 32];
        active = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && pend_q);
        skip   = we_q && (nib == 4'h0);
    end

    // Outputs depend only on registered state, so reset clears them at once.
    always_comb begin
        sram_stb  = ((state_q == ST_RUN) && !skip) || ((state_q == ST_DRAIN) && pend_q);
        sram_addr = active ? word_addr(base_q, idx_q) : 32'h0;
        sram_we   = (active && we_q) ? nib : 4'h0;
        sram_din  = active ? word : 32'h0;
        ws_ack    = (state_q == ST_ACK);
        ws_dout   = dout_q;
        dbg_state = state_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        we_d    = we_q;
        din_d   = din_q;
        dm_d    = dm_q;
        line_d  = line_q;
        dout_d  = dout_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (ws_cyc && ws_stb) begin
                    base_d  = ws_addr[31:6];
                    we_d    = ws_we;
                    din_d   = ws_din;
                    dm_d    = ws_dm;
                    idx_d   = 4'h0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ws_cyc) begin
                    // A word still being nak'd must stay on the bus until accepted.
                    pend_d  = !skip && sram_nak;
                    state_d = ST_DRAIN;
                end else if (skip || !sram_nak) begin
                    if (!we_q) begin
                        line_d[{idx_q, 5'b00000} +: 32] = sram_dout;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ACK;
                        if (!we_q) begin
                            dout_d = line_d;
                        end
                    end else begin
                        idx_d = idx_q + 4'h1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!pend_q || !sram_nak) begin
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkCPU or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            dm_q    <= '0;
            line_q  <= '0;
            dout_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            we_q    <= we_d;
            din_q   <= din_d;
            dm_q    <= dm_d;
            line_q  <= line_d;
            dout_q  <= dout_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_line_sram_bridge.sv
// Scoreboard bench: driver queues expected word accesses and acks, negedge monitor checks them.
module tb_line_sram_bridge;

    logic         clkCPU = 1'b0;
    logic         rstn = 1'b0;
    logic         ws_cyc = 1'b0, ws_stb = 1'b0, ws_we = 1'b0;
    logic [31:0]  ws_addr = '0;
    logic [511:0] ws_din = '0;
    logic [63:0]  ws_dm = '0;
    logic [511:0] ws_dout;
    logic         ws_ack;
    logic         sram_stb;
    logic [31:0]  sram_addr;
    logic [3:0]   sram_we;
    logic [31:0]  sram_din;
    logic [31:0]  sram_dout = '0;
    logic         sram_nak = 1'b0;
    logic [1:0]   dbg_state;

    always #5 clkCPU = ~clkCPU;

    line_sram_bridge #(.WORDS(16)) dut (
        .clkCPU(clkCPU), .rstn(rstn),
        .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we), .ws_addr(ws_addr),
        .ws_din(ws_din), .ws_dm(ws_dm), .ws_dout(ws_dout), .ws_ack(ws_ack),
        .sram_stb(sram_stb), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_din(sram_din), .sram_dout(sram_dout), .sram_nak(sram_nak),
        .dbg_state(dbg_state)
    );

    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] din; } acc_t;
    typedef struct { logic [511:0] dout; int t0; } ack_t;

    acc_t         acc_q[$];
    ack_t         ack_exp[$];
    int           errors = 0, checks = 0;
    int           cyc_cnt = 0;
    logic [511:0] last_line = '0;
    logic [31:0]  salt = '0;
    int           nak_word = -1, nak_cycles = 0, nak_cnt = 0, nak_total = 0;
    bit           nak_rand = 1'b0;
    int           acks_seen = 0;

    acc_t        e_acc;
    ack_t        e_ack;
    logic        hold = 1'b0, prev_ack = 1'b0;
    logic [31:0] p_addr, p_din;
    logic [3:0]  p_we;

    always @(posedge clkCPU) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Responder plus monitor; responder decides nak first so the monitor sees the final value.
    always @(negedge clkCPU) begin
        if (!rstn) begin
            sram_nak = 1'b0;
            hold     = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (sram_stb) begin
                sram_dout = 32'hA000_0000 + {28'h0, sram_addr[5:2]} + salt;
                if (nak_word == int'(sram_addr[5:2]) && nak_cnt < nak_cycles) begin
                    sram_nak = 1'b1;
                    nak_cnt++;
                end else if (nak_rand) begin
                    sram_nak = ($urandom_range(0, 3) == 0);
                end else begin
                    sram_nak = 1'b0;
                end
                if (sram_nak) nak_total++;
            end else begin
                sram_nak = 1'b0;
            end

            if (hold) begin
                check("hold_stb", sram_stb, 1'b1);
                check("hold_addr", sram_addr, p_addr);
                check("hold_we", sram_we, p_we);
                check("hold_din", sram_din, p_din);
            end
            hold   = sram_stb && sram_nak;
            p_addr = sram_addr;
            p_we   = sram_we;
            p_din  = sram_din;

            if (sram_stb && !sram_nak) begin
                if (acc_q.size() == 0) begin
                    fail_now($sformatf("unexpected_word addr=%0h", sram_addr));
                end else begin
                    e_acc = acc_q.pop_front();
                    check("word_addr", sram_addr, e_acc.addr);
                    check("word_we", sram_we, e_acc.we);
                    check("word_din", sram_din, e_acc.din);
                end
            end

            if (ws_ack) begin
                acks_seen++;
                check("ack_one_cycle", prev_ack, 1'b0);
                if (ack_exp.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e_ack = ack_exp.pop_front();
                    check("ack_latency", cyc_cnt - e_ack.t0, 17 + nak_total);
                    check("ack_dout", ws_dout, e_ack.dout);
                end
            end
            prev_ack = ws_ack;
        end
    end

    // mode 0: normal, 1: drop ws_cyc at word 8, 2: reset at word 10
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [511:0] din,
                           input logic [63:0] dm, input int mode);
        logic [511:0] line;
        logic [31:0]  base;
        logic [3:0]   nib;
        int           limit;
        int           k;
        int           acks0;
        @(negedge clkCPU);
        for (k = 0; k < 50 && dbg_state != 2'b00; k++) @(negedge clkCPU);
        if (dbg_state != 2'b00) fail_now("timeout_idle");

        base  = {addr[31:6], 6'h0};
        limit = (mode == 1) ? 9 : 16;
        for (int i = 0; i < limit; i++) begin
            nib = dm[4*i +: 4];
            if (!we || nib != 4'h0)
                acc_q.push_back('{addr: base + 32'(4*i), we: (we ? nib : 4'h0), din: din[32*i +: 32]});
        end
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'hA000_0000 + 32'(i) + salt;

        nak_cnt   = 0;
        nak_total = 0;
        acks0     = acks_seen;
        if (mode == 0) begin
            ack_exp.push_back('{dout: (we ? last_line : line), t0: cyc_cnt});
            if (!we) last_line = line;
        end
        ws_cyc = 1'b1; ws_stb = 1'b1; ws_we = we; ws_addr = addr; ws_din = din; ws_dm = dm;
        @(posedge clkCPU);
        #1 ws_stb = 1'b0;

        if (mode == 0) begin
            for (k = 0; k < 200 && !ws_ack; k++) @(negedge clkCPU);
            if (!ws_ack) fail_now("timeout_ack");
            ws_cyc = 1'b0;
        end else if (mode == 1) begin
            for (k = 0; k < 200 && !(sram_stb && sram_addr[5:2] == 4'd8); k++) @(negedge clkCPU);
            ws_cyc = 1'b0;
            @(negedge clkCPU);
            check("drain_state", dbg_state, 2'b11);
            check("drain_stb", sram_stb, 1'b1);
            for (k = 0; k < 20 && dbg_state != 2'b00; k++) @(negedge clkCPU);
            check("drain_idle", dbg_state, 2'b00);
            check("drain_no_ack", acks_seen - acks0, 0);
            check("drain_words_left", acc_q.size(), 0);
        end else begin
            for (k = 0; k < 200 && !(sram_stb && sram_addr[5:2] == 4'd10); k++) @(negedge clkCPU);
            #2 rstn = 1'b0;
            ws_cyc = 1'b0;
            #1;
            check("rst_state", dbg_state, 2'b00);
            check("rst_stb", sram_stb, 1'b0);
            check("rst_addr", sram_addr, 32'h0);
            check("rst_we", sram_we, 4'h0);
            check("rst_din", sram_din, 32'h0);
            check("rst_ack", ws_ack, 1'b0);
            check("rst_dout", ws_dout, 512'h0);
            acc_q.delete();
            ack_exp.delete();
            last_line = '0;
            repeat (2) @(negedge clkCPU);
            rstn = 1'b1;
            check("rst_no_ack", acks_seen - acks0, 0);
        end
    endtask

    initial begin
        logic [511:0] din;
        logic [63:0]  dm;
        int           r;

        #12;
        check("reset_state", dbg_state, 2'b00);
        check("reset_stb", sram_stb, 1'b0);
        check("reset_addr", sram_addr, 32'h0);
        check("reset_we", sram_we, 4'h0);
        check("reset_din", sram_din, 32'h0);
        check("reset_ack", ws_ack, 1'b0);
        check("reset_dout", ws_dout, 512'h0);
        @(negedge clkCPU);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) din[32*i +: 32] = 32'(i);
        run_txn(1'b0, 32'h1000_0040, din, '1, 0);
        run_txn(1'b1, 32'h1000_0040, din, '1, 0);
        run_txn(1'b1, 32'h2000_0080, din, 64'h0000_0000_0000_00F0, 0);

        nak_word = 5; nak_cycles = 3;
        run_txn(1'b0, 32'h1000_0040, din, '0, 0);
        nak_word = 8;
        run_txn(1'b0, 32'h3000_0100, din, '0, 1);
        nak_word = -1; nak_cycles = 0;
        run_txn(1'b1, 32'h3000_0140, din, 64'h0F00_0000_0000_0001, 0);
        run_txn(1'b0, 32'h4000_0000, din, '0, 2);
        run_txn(1'b1, 32'h4000_0040, din, '1, 0);
        run_txn(1'b0, 32'h4000_0000, din, '0, 0);

        nak_rand = 1'b1;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                din[32*i +: 32] = $urandom;
                r = $urandom_range(0, 2);
                dm[4*i +: 4] = (r == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            salt = $urandom;
            run_txn(1'($urandom_range(0, 1)), $urandom, din, dm, 0);
        end
        nak_rand = 1'b0;

        repeat (3) @(negedge clkCPU);
        check("end_words_left", acc_q.size(), 0);
        check("end_acks_left", ack_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
